// File: rtl/rc4_pkg.sv
// RC4 shared definitions for the fill, KSA and PRGA stages.
// Holds S-array sizing, key length, KSA state encoding and key-byte helper.
package rc4_pkg;

    localparam int S_SIZE  = 256;
    localparam int KEY_LEN = 3;
    localparam int KEY_MAX = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_I,
        LAT_I,
        RD_J,
        LAT_J,
        WR_I,
        WR_J
    } ksa_state_t;

    // Byte idx mod len of a key stored most-significant byte first.
    function automatic logic [7:0] keybyte(
        input logic [8*KEY_MAX-1:0] key,
        input logic [7:0]           idx,
        input int unsigned          len = KEY_LEN
    );
        int unsigned pos;
        pos = len - 1 - (32'(idx) % len);
        return key[8*pos +: 8];
    endfunction

endpackage

// File: rtl/ksa.sv
// RC4 key-scheduling stage: permutes S in place over the shared memory port.
// Build option KSA_SELF_SWAP_SKIP_EN drops the write pair when j==i.
module ksa #(
    parameter int KEY_LEN = rc4_pkg::KEY_LEN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic               rdy,
    input  logic [8*KEY_LEN-1:0] key,
    output logic [7:0]         addr,
    input  logic [7:0]         rddata,
    output logic [7:0]         wrdata,
    output logic               wren
);
    import rc4_pkg::*;

    ksa_state_t state_q, state_d;

    logic [7:0] i_q, i_d;
    logic [7:0] j_q, j_d;
    logic [7:0] si_q, si_d;
    logic [7:0] sj_q, sj_d;
    logic [8*KEY_LEN-1:0] key_q, key_d;

    logic [7:0] addr_q, addr_d;
    logic [7:0] wrdata_q, wrdata_d;
    logic       wren_q, wren_d;

    logic [8*KEY_MAX-1:0] key_ext;
    logic [7:0] kb;
    logic [7:0] j_sum;
    logic       last;
    logic       skip;

    assign key_ext = (8*KEY_MAX)'(key_q);
    assign kb      = keybyte(key_ext, i_q, KEY_LEN);
    assign j_sum   = j_q + rddata + kb;
    assign last    = (i_q == 8'(S_SIZE - 1));

`ifdef KSA_SELF_SWAP_SKIP_EN
    assign skip = (state_q == RD_J) && (j_q == i_q);
`else
    assign skip = 1'b0;
`endif

    assign rdy    = (state_q == IDLE);
    assign addr   = addr_q;
    assign wrdata = wrdata_q;
    assign wren   = wren_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        key_d   = key_q;
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RD_I;
                    i_d     = '0;
                    j_d     = '0;
                    key_d   = key;
                end
            end
            RD_I: state_d = LAT_I;
            LAT_I: begin
                state_d = RD_J;
                si_d    = rddata;
                j_d     = j_sum;
            end
            RD_J: begin
                if (skip) begin
                    state_d = last ? IDLE : RD_I;
                    i_d     = i_q + 8'd1;
                end else begin
                    state_d = LAT_J;
                end
            end
            LAT_J: begin
                state_d = WR_I;
                sj_d    = rddata;
            end
            WR_I: state_d = WR_J;
            WR_J: begin
                state_d = last ? IDLE : RD_I;
                i_d     = i_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory-port outputs are registered, so they follow the state being entered.
    always_comb begin
        addr_d   = addr_q;
        wrdata_d = wrdata_q;
        wren_d   = 1'b0;
        unique case (state_d)
            RD_I: addr_d = i_d;
            RD_J: addr_d = j_d;
            WR_I: begin
                addr_d   = i_d;
                wrdata_d = sj_d;
                wren_d   = 1'b1;
            end
            WR_J: begin
                addr_d   = j_d;
                wrdata_d = si_d;
                wren_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q      <= '0;
            j_q      <= '0;
            si_q     <= '0;
            sj_q     <= '0;
            key_q    <= '0;
            addr_q   <= '0;
            wrdata_q <= '0;
            wren_q   <= 1'b0;
        end else begin
            i_q      <= i_d;
            j_q      <= j_d;
            si_q     <= si_d;
            sj_q     <= sj_d;
            key_q    <= key_d;
            addr_q   <= addr_d;
            wrdata_q <= wrdata_d;
            wren_q   <= wren_d;
        end
    end

endmodule

// File: doc/ksa.md
# ksa

RC4 key-scheduling stage: takes the identity-filled 256-byte S-array that the fill stage leaves in the shared single-port S memory and permutes it in place using a 24-bit secret key. For i = 0..255 it computes j = (j + S[i] + key[i mod 3]) mod 256 and swaps S[i] and S[j]. It sits directly downstream of the fill stage and upstream of the PRGA stage. The top-level controller arbitrates the S-memory port and sequences the stages with the same rdy/en handshake.

## Interface
Parameters:
- KEY_LEN, 3, key length in bytes; key[i mod KEY_LEN] is selected most-significant byte first.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- en  in  1  start request; sampled only while rdy=1
- rdy  out  1  high when idle and able to accept en
- key  in  8*KEY_LEN  secret key; key[8*KEY_LEN-1 -: 8] is byte 0
- addr  out  8  S-memory address
- rddata  in  8  S-memory read data; valid one cycle after addr is presented with wren=0
- wrdata  out  8  S-memory write data
- wren  out  1  S-memory write enable

## Operation
- Reset values: state IDLE, rdy=1, addr=0, wrdata=0, wren=0, i=0, j=0, latched key=0.
- IDLE:
  - rdy=1.
  - When en=1, latch key, clear i and j, and go to RD_I.
  - en=0 stays in IDLE.
- Per-iteration state sequence. rdy=0 in every state except IDLE.
  - RD_I: addr=i, wren=0.
  - LAT_I: si <= rddata; j <= j + rddata + keybyte(i mod KEY_LEN), 8-bit wrap.
  - RD_J: addr=j, wren=0.
  - LAT_J: sj <= rddata.
  - WR_I: addr=i, wrdata=sj, wren=1.
  - WR_J: addr=j, wrdata=si, wren=1. Then i <= i+1. If i was 255, go to IDLE; otherwise go to RD_I.
- i==j: the sequence reads S[i] twice and writes the same value twice, so the array is unchanged.
- i wraps 255->0 only at completion. j is cleared on start and never on completion.
- en or key changes while busy are ignored. The latched key is used for the whole run.
- Asynchronous reset mid-run aborts immediately. The memory is left partially permuted; rdy=1 and wren=0 at once.
- The block has no sticky done flag. Completion is signalled by rdy rising.

## Timing
- Outputs addr, wrdata and wren are registered.
- rdy is decoded from the state register (state==IDLE).
- en accepted at edge E:
  - rdy=0 from cycle E+1.
  - First RD_I occupies cycle E+1.
- Each iteration takes 6 cycles, so a full run is 1536 cycles. The final WR_J occupies cycle E+1536, and rdy=1 from cycle E+1537.
- Back-to-back: en held high while rdy=1 restarts on the first idle edge. There is no dead cycle beyond that IDLE cycle.
- The memory read latency is exactly 1 cycle. The block never reads the address it wrote in the preceding cycle within one iteration.

## Configuration
- KSA_SELF_SWAP_SKIP_EN:
  - Defined: in RD_J, if j==i, suppress both writes and advance i directly. That iteration takes 3 cycles (RD_I, LAT_I, RD_J), and run length becomes 1536 − 3·(number of self-swap iterations).
  - Undefined: every iteration takes 6 cycles, including redundant writes.
- The final S contents are identical in both builds.

## Structure
- Shared package rc4_pkg holds:
  - S_SIZE=256.
  - Default KEY_LEN=3.
  - The ksa_state_t enum (IDLE, RD_I, LAT_I, RD_J, LAT_J, WR_I, WR_J).
  - A keybyte(key, idx) function.
- The same package is reused by the fill and PRGA stages.
- No sub-module. The datapath (i, j, si, sj, mux) is small enough to stay flat in ksa.

## Test plan
- Reset: assert rst_n=0 mid-cycle → outputs go immediately to rdy=1, wren=0, addr=0; state stays IDLE until en.
- Key 0x010203 on an identity S: iteration 0 gives j=1, with writes S[0]=1 (WR_I) then S[1]=0 (WR_J). Iteration 1 gives j=1+0+0x02=3, with writes S[1]=3 then S[3]=0.
- Key 0x000000, macro undefined: rdy low for exactly 1536 cycles; the final S matches the reference model byte-for-byte.
- Key 0x000000, macro defined: iterations 0 and 1 (j=0, j=1) each take 3 cycles with no wren pulse; the final S equals the undefined-build result.
- en pulsed and key changed at cycle E+100 → no restart, the run completes at E+1536 using the original key, and the final S matches the model.
- rst_n asserted at cycle E+700, then en with the same key after the fill stage re-runs → rdy rises immediately on reset; the second run's final S matches the model.
